// File: rtl/video_wr_packer.sv
// video_wr_packer: packs active-video pixels into addressed memory words and
// buffers them in a small FIFO drained over a req/ack write port.
module video_wr_packer #(
    parameter int PIX_W      = 8,
    parameter int PACK       = 4,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          hav,
    input  logic                          vav,
    input  logic [PIX_W-1:0]              pix_data,
    output logic                          wr_req,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [PIX_W*PACK-1:0]         wr_data,
    input  logic                          wr_ack,
    output logic                          frame_start,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(PACK);
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam int WW = PIX_W * PACK;
    localparam int EW = ADDR_W + WW;

    logic              hav_prev, vav_prev;
    logic [CW-1:0]     pack_cnt;
    logic [WW-1:0]     pack_reg, next_word;
    logic [ADDR_W-1:0] addr_cnt;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     last_head;
    logic [LW:0]       wr_ptr, rd_ptr;
    logic              rise, fall, push, pop, full, keep;

    always_comb begin
        next_word = pack_reg;
        for (int i = 0; i < PACK; i++)
            if (hav && pack_cnt == CW'(i)) next_word[i*PIX_W +: PIX_W] = pix_data;
    end

    // A frame start wins over word completion and line-end flush: the partial word is discarded.
    assign rise       = vav & ~vav_prev;
    assign fall       = hav_prev & ~hav;
    assign push       = ~rise & ((hav & (pack_cnt == CW'(PACK - 1))) | (fall & (pack_cnt != '0)));
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = fifo_level == (LW + 1)'(FIFO_DEPTH);
    assign wr_req     = fifo_level != '0;
    assign pop        = wr_req & wr_ack;
    assign keep       = push & (~full | pop);
    // When empty the port shows the last head that was accepted.
    assign {wr_addr, wr_data} = wr_req ? mem[rd_ptr[LW-1:0]] : last_head;

    always_ff @(posedge clk)
        if (keep) mem[wr_ptr[LW-1:0]] <= {addr_cnt, next_word};

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hav_prev    <= 1'b0;
            vav_prev    <= 1'b0;
            frame_start <= 1'b0;
            pack_cnt    <= '0;
            pack_reg    <= '0;
            addr_cnt    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_head   <= '0;
            overflow    <= 1'b0;
        end else begin
            hav_prev    <= hav;
            vav_prev    <= vav;
            frame_start <= rise;
            pack_cnt    <= (rise | push) ? '0 : hav ? pack_cnt + 1'b1 : pack_cnt;
            pack_reg    <= (rise | push) ? '0 : next_word;
            addr_cnt    <= rise ? '0 : push ? addr_cnt + 1'b1 : addr_cnt;
            wr_ptr      <= wr_ptr + (LW + 1)'(keep);
            rd_ptr      <= rd_ptr + (LW + 1)'(pop);
            if (pop) last_head <= mem[rd_ptr[LW-1:0]];
            if (push & full & ~pop) overflow <= 1'b1;
        end
    end
endmodule
